serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, the block's only clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to add the current a, b and cin.
REQ-005 The block SHALL have port a  input  WIDTH  first operand.
REQ-006 The block SHALL have port b  input  WIDTH  second operand.
REQ-007 The block SHALL have port cin  input  1  carry-in.
REQ-008 The block SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum  output  WIDTH  result, a+b+cin modulo 2^WIDTH.
REQ-011 The block SHALL have port cout  output  1  carry-out of the WIDTH-bit addition.

Function
REQ-012 The block SHALL be a bit-serial adder: one full-add per clock, LSB first, driven by a 1-bit carry register.
REQ-013 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE, all outputs registered.
REQ-014 IDLE, start=1 at edge k: the block SHALL capture a, b and cin into internal shift and carry registers, clear the bit counter and enter RUN.
REQ-015 IDLE, start=0: the block SHALL remain in IDLE with sum, cout and busy unchanged.
REQ-016 RUN, each edge: the block SHALL full-add the operand LSBs with the carry register, shift the sum bit into the result register MSB, shift both operands right by one, store the new carry and increment the counter.
REQ-017 RUN: after exactly WIDTH bit-edges (edges k+1..k+WIDTH) the block SHALL load the result into sum, load the final carry into cout and enter DONE.
REQ-018 busy SHALL be 1 after edges k through k+WIDTH-1 and 0 otherwise.
REQ-019 done SHALL be 1 only in the cycle after edge k+WIDTH, and the block SHALL then return to IDLE at edge k+WIDTH+1.
REQ-020 sum and cout SHALL change only on the RUN-to-DONE transition or on reset, holding the previous result throughout RUN; partial results SHALL never be visible.
REQ-021 The block SHALL ignore start in RUN and DONE, with no effect on the operation in progress.
REQ-022 start sampled in the IDLE cycle immediately after DONE SHALL be accepted, giving a minimum issue interval of WIDTH+2 cycles.
REQ-023 Changes to a, b and cin after the start edge SHALL NOT affect the result.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE with busy=0, done=0, sum=0, cout=0, and clear the counter, carry and shift registers.
REQ-026 rst SHALL override start and any in-flight addition, aborting it with no done pulse and no update of sum or cout.
REQ-027 After rst is deasserted, the first start sampled in IDLE SHALL behave as in REQ-014.

Verification (WIDTH=8)
REQ-028 The bench SHALL check: a=0x00, b=0x00, cin=0 -> done after 8 edges, sum=0x00, cout=0; sweep all four LSB combinations of a and b against the half/full-add truth table.
REQ-029 The bench SHALL check: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; and a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-030 The bench SHALL check: a=0x3C, b=0x41, cin=0 -> sum=0x7D, cout=0; busy high for exactly 8 cycles, done high for exactly 1 cycle, sum stable during RUN.
REQ-031 The bench SHALL check: start re-pulsed with new operands during RUN and during DONE -> ignored, the original result is delivered, and no second done pulse occurs.
REQ-032 The bench SHALL check: rst asserted at bit 4 of an addition -> next cycle busy=0, done=0, sum=0, cout=0, and no done pulse follows.
REQ-033 The bench SHALL check back-to-back operations, start in the IDLE cycle after done: 0x01+0x01 then 0x80+0x80 -> sum=0x02, cout=0 then sum=0x00, cout=1, with a 10-cycle spacing between done pulses.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add per clock, LSB first, through a 1-bit carry register.
// A result appears on sum/cout only when the last bit has been added; done pulses for one cycle.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [CW-1:0]    cnt_reg, cnt_next;

    logic sum_bit;
    logic carry_bit;
    logic last_bit;

    assign sum_bit   = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign carry_bit = (a_reg[0] & b_reg[0]) | (carry_reg & (a_reg[0] ^ b_reg[0]));
    assign last_bit  = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        res_next   = res_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        cout_next  = cout_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    carry_next = cin;
                    res_next   = '0;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_next     = a_reg >> 1;
                b_next     = b_reg >> 1;
                carry_next = carry_bit;
                res_next   = {sum_bit, res_reg[WIDTH-1:1]};
                cnt_next   = cnt_reg + CW'(1);
                if (last_bit) begin
                    // The shifted-in final bit completes the result in the same edge.
                    sum_next   = {sum_bit, res_reg[WIDTH-1:1]};
                    cout_next  = carry_bit;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            cout_reg  <= cout_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes expected {cout,sum},
// a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    logic [8:0] exp_q[$];

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            logic [8:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got cout=%0b sum=%02h, required no done", cout, sum);
            end else begin
                e = exp_q.pop_front();
                if ({cout, sum} !== e) begin
                    bad++;
                    $display("FAIL result: got cout=%0b sum=%02h, required cout=%0b sum=%02h",
                             cout, sum, e[8], e[7:0]);
                end else begin
                    $display("result ok: cout=%0b sum=%02h", cout, sum);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Called just after a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic [8:0] expv, input bit push);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk);
        if (push) exp_q.push_back(expv);
        #1;
        start = 1'b0;
        a = ~ia; b = ~ib; cin = ~ic;   // later input changes must not matter
        $display("issue a=%02h b=%02h cin=%0b", ia, ib, ic);
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done, required done within 30 cycles", name);
        end
    endtask

    task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                      input logic [8:0] expv);
        issue(ia, ib, ic, expv, 1'b1);
        wait_done("op");
        @(negedge clk);
    endtask

    initial begin
        int bcnt;
        int t1;
        bit saw_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);

        // Zero and LSB full-add truth table
        op(8'h00, 8'h00, 1'b0, {1'b0, 8'h00});
        op(8'h00, 8'h00, 1'b1, {1'b0, 8'h01});
        op(8'h01, 8'h00, 1'b0, {1'b0, 8'h01});
        op(8'h00, 8'h01, 1'b1, {1'b0, 8'h02});
        op(8'h01, 8'h01, 1'b0, {1'b0, 8'h02});
        op(8'h01, 8'h01, 1'b1, {1'b0, 8'h03});

        // Busy width, done width and sum stability while running (previous sum is 0x03)
        issue(8'h3C, 8'h41, 1'b0, {1'b0, 8'h7D}, 1'b1);
        bcnt = 0;
        @(negedge clk);
        while (busy && bcnt < 30) begin
            bcnt++;
            check("sum_hold_run", {cout, sum}, {1'b0, 8'h03});
            @(negedge clk);
        end
        check("busy_cycles", bcnt, 8);
        check("done_after_busy", done, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        op(8'hFF, 8'h01, 1'b0, {1'b1, 8'h00});
        op(8'hA5, 8'h5A, 1'b1, {1'b1, 8'h00});

        // start re-pulsed during RUN and during DONE must be ignored
        issue(8'h12, 8'h34, 1'b0, {1'b0, 8'h46}, 1'b1);
        repeat (3) @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore");
        a = 8'hEE; b = 8'h11; cin = 1'b1; start = 1'b1;   // sampled while in DONE
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("ignore_no_busy", busy, 0);
        check("ignore_sum_kept", {cout, sum}, {1'b0, 8'h46});

        // Reset at bit 4 aborts the operation
        issue(8'h77, 8'h11, 1'b0, 9'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        saw_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);

        // Back-to-back: second start in the IDLE cycle right after DONE
        @(negedge clk);
        issue(8'h01, 8'h01, 1'b0, {1'b0, 8'h02}, 1'b1);
        wait_done("b2b_first");
        t1 = cycle;
        @(negedge clk);
        issue(8'h80, 8'h80, 1'b0, {1'b1, 8'h00}, 1'b1);
        wait_done("b2b_second");
        check("b2b_spacing", cycle - t1, 10);
        repeat (3) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
